// File: rtl/fifo_rd_stream.sv
// Fixed-latency FIFO read port to first-word-fall-through valid/ready stream with skid buffer.
// Define FIFO_RD_STREAM_REG_OUT_EN for a registered RAM output (read latency 2 instead of 1).
module fifo_rd_stream #(
    parameter int DW    = 16,
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fifo_empty_i,
    input  logic [DW-1:0]    fifo_dt_i,
    output logic             fifo_pop_o,
    output logic             fifo_flush_o,
    input  logic             flush_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [DW-1:0]    m_dt_o,
    output logic [CNT_W-1:0] level_o,
    output logic             busy_o
);

`ifdef FIFO_RD_STREAM_REG_OUT_EN
    localparam int RAM_LAT = 2;
`else
    localparam int RAM_LAT = 1;
`endif
    localparam int BUF_DEPTH = RAM_LAT + 1;
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    localparam int OCC_W     = CNT_W + 1;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   level_r;
    logic [CNT_W-1:0]   inflight_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [DW-1:0]      buf_r [BUF_DEPTH];
    logic [RAM_LAT-1:0] pend_r;
    logic               valid_r;
    logic               busy_r;
    logic               flush_pulse_r;

    logic               run_s;
    logic               xfer_s;
    logic               ret_s;
    logic               cap_s;
    logic               pop_s;
    logic [OCC_W-1:0]   occ_s;
    logic [CNT_W-1:0]   level_nxt_s;
    logic [CNT_W-1:0]   inflight_nxt_s;
    logic [RAM_LAT-1:0] pend_nxt_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Handshake, pop admission and next-state counters; flush_i blocks both pop and transfer.
    always_comb begin
        run_s          = (state_r == ST_RUN) && !flush_i;
        xfer_s         = valid_r && m_ready_i && run_s;
        ret_s          = pend_r[RAM_LAT-1];
        cap_s          = ret_s && run_s;
        occ_s          = OCC_W'(inflight_r) + OCC_W'(level_r) - OCC_W'(xfer_s);
        pop_s          = run_s && !rst_i && !fifo_empty_i && (occ_s < OCC_W'(BUF_DEPTH));
        level_nxt_s    = level_r + CNT_W'(cap_s) - CNT_W'(xfer_s);
        inflight_nxt_s = inflight_r + CNT_W'(pop_s) - CNT_W'(ret_s);
        // pend_r[k] marks a pop issued k+1 cycles ago; the top bit is the word on fifo_dt_i now
        pend_nxt_s     = RAM_LAT'({pend_r, pop_s});
    end

    // Run/flush state machine with buffer, counters and registered status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r       <= ST_RUN;
            level_r       <= '0;
            inflight_r    <= '0;
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            pend_r        <= '0;
            valid_r       <= 1'b0;
            busy_r        <= 1'b0;
            flush_pulse_r <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_r[i] <= '0;
            end
        end else begin
            pend_r        <= pend_nxt_s;
            inflight_r    <= inflight_nxt_s;
            flush_pulse_r <= flush_i;
            case (state_r)
                ST_RUN: begin
                    if (flush_i) begin
                        state_r  <= ST_FLUSH;
                        level_r  <= '0;
                        wr_ptr_r <= '0;
                        rd_ptr_r <= '0;
                        valid_r  <= 1'b0;
                        busy_r   <= 1'b1;
                    end else begin
                        if (cap_s) begin
                            buf_r[wr_ptr_r] <= fifo_dt_i;
                            wr_ptr_r        <= ptr_inc(wr_ptr_r);
                        end
                        if (xfer_s) begin
                            rd_ptr_r <= ptr_inc(rd_ptr_r);
                        end
                        level_r <= level_nxt_s;
                        valid_r <= (level_nxt_s != '0);
                        busy_r  <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    // Returning words are dropped simply by never capturing them here
                    level_r  <= '0;
                    wr_ptr_r <= '0;
                    rd_ptr_r <= '0;
                    valid_r  <= 1'b0;
                    if (!flush_i && (inflight_r == '0)) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_FLUSH;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_RUN;
                    level_r  <= '0;
                    wr_ptr_r <= '0;
                    rd_ptr_r <= '0;
                    valid_r  <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_pop_o   = pop_s;
    assign fifo_flush_o = flush_pulse_r;
    assign m_valid_o    = valid_r;
    assign m_dt_o       = buf_r[rd_ptr_r];
    assign level_o      = level_r;
    assign busy_o       = busy_r;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: FIFO/RAM model, data scoreboard and per-cycle vector table.
module tb_fifo_rd_stream;

`ifdef FIFO_RD_STREAM_REG_OUT_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int BUF = LAT + 1;
    localparam int NV  = 14;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        fifo_empty_i = 1'b1;
    logic [15:0] fifo_dt_i = 16'h0000;
    logic        fifo_pop_o;
    logic        fifo_flush_o;
    logic        flush_i = 1'b0;
    logic        m_valid_o;
    logic        m_ready_i = 1'b0;
    logic [15:0] m_dt_o;
    logic [1:0]  level_o;
    logic        busy_o;

    fifo_rd_stream #(.DW(16), .CNT_W(2)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_dt_i    (fifo_dt_i),
        .fifo_pop_o   (fifo_pop_o),
        .fifo_flush_o (fifo_flush_o),
        .flush_i      (flush_i),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_dt_o       (m_dt_o),
        .level_o      (level_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       ready;
        logic       exp_pop;
        logic       exp_valid;
        logic [1:0] exp_level;
    } vec_t;

    typedef struct {
        logic [15:0] w;
        int          due;
    } ret_t;

    vec_t        tbl [NV];
    logic [15:0] fq [$];
    logic [15:0] exp_q [$];
    ret_t        rq [$];

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_pop = 0;
    int   n_xfer = 0;
    int   lvl_max = 0;
    logic rst_v = 1'b1;
    logic flush_v = 1'b0;
    logic ready_v = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, exp_v);
        end
    endtask

    // One clock: drive inputs 1 unit after the edge, model FIFO/RAM and score outputs 4 units after.
    task automatic tick();
        ret_t        r;
        logic [15:0] e;
        @(posedge clk_i);
        #1;
        cyc++;
        rst_i        = rst_v;
        flush_i      = flush_v;
        m_ready_i    = ready_v;
        fifo_empty_i = (fq.size() == 0);
        if (rq.size() != 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            fifo_dt_i = r.w;
        end else begin
            fifo_dt_i = 16'hDEAD;
        end
        #3;
        if (fifo_pop_o) begin
            chk("pop_while_empty", 32'(fifo_empty_i), 32'd0);
            n_pop++;
            if (fq.size() != 0) begin
                r.w   = fq.pop_front();
                r.due = cyc + LAT;
                rq.push_back(r);
            end
        end
        if (m_valid_o && m_ready_i && !flush_i && !rst_i) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_xfer (cycle %0d): got %0h, expected no transfer", cyc, m_dt_o);
            end else begin
                e = exp_q.pop_front();
                chk("stream_data", 32'(m_dt_o), 32'(e));
            end
        end
        if (flush_i) exp_q.delete();
        if (fifo_flush_o) fq.delete();
        if (int'(level_o) > lvl_max) lvl_max = int'(level_o);
    endtask

    task automatic load(input logic [15:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic drain(input int budget, input string nm);
        int k = 0;
        ready_v = 1'b1;
        while ((exp_q.size() != 0 || m_valid_o) && k < budget) begin
            tick();
            k++;
        end
        chk(nm, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_stream(input string tag);
        for (int i = 1; i <= 8; i++) load(16'(i));
        for (int c = 0; c < NV; c++) begin
            ready_v = tbl[c].ready;
            tick();
            chk({tag, "_pop"}, 32'(fifo_pop_o), 32'(tbl[c].exp_pop));
            chk({tag, "_valid"}, 32'(m_valid_o), 32'(tbl[c].exp_valid));
            chk({tag, "_level"}, 32'(level_o), 32'(tbl[c].exp_level));
        end
        chk({tag, "_all_out"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_pop"}, 32'(fifo_pop_o), 32'd0);
        chk({tag, "_flush_o"}, 32'(fifo_flush_o), 32'd0);
        chk({tag, "_valid"}, 32'(m_valid_o), 32'd0);
        chk({tag, "_dt"}, 32'(m_dt_o), 32'd0);
        chk({tag, "_level"}, 32'(level_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int xs;
        int k;
        // Streaming with ready=1: pops in cycles 0..7, first word visible LAT+1 cycles after the first pop
        for (int c = 0; c < NV; c++) begin
            tbl[c].ready     = 1'b1;
            tbl[c].exp_pop   = (c < 8);
            tbl[c].exp_valid = (c >= LAT + 1) && (c <= LAT + 8);
            tbl[c].exp_level = tbl[c].exp_valid ? 2'd1 : 2'd0;
        end

        #1 rst_i = 1'b1;
        #2;
        chk_zero_outputs("reset");
        tick();
        tick();
        rst_v = 1'b0;
        tick();
        tick();
        chk("idle_valid", 32'(m_valid_o), 32'd0);

        run_stream("stream");

        // Backpressure: buffer fills to BUF words, head held stable
        for (int i = 1; i <= 8; i++) load(16'(i));
        n_pop   = 0;
        ready_v = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("bp_pops", 32'(n_pop), 32'(BUF));
        chk("bp_level", 32'(level_o), 32'(BUF));
        chk("bp_valid", 32'(m_valid_o), 32'd1);
        chk("bp_head", 32'(m_dt_o), 32'h0001);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("bp_head_stable", 32'(m_dt_o), 32'h0001);
        end
        xs = n_xfer;
        drain(40, "bp_drain");
        chk("bp_count", 32'(n_xfer - xs), 32'd8);

        // Alternating ready over 16 words
        for (int i = 0; i < 16; i++) load(16'h0100 + 16'(i));
        lvl_max = 0;
        xs = n_xfer;
        k  = 0;
        while ((n_xfer - xs) < 16 && k < 120) begin
            ready_v = ~ready_v;
            tick();
            k++;
        end
        chk("alt_count", 32'(n_xfer - xs), 32'd16);
        chk("alt_level_max_ok", 32'(lvl_max <= BUF), 32'd1);
        ready_v = 1'b1;
        tick();
        tick();
        chk("alt_idle_level", 32'(level_o), 32'd0);

        // Mid-stream flush, back-to-back second flush while already flushing
        for (int i = 0; i < 8; i++) load(16'h0010 + 16'(i));
        for (int i = 0; i < 4; i++) tick();
        chk("pre_flush_valid", 32'(m_valid_o), 32'd1);
        flush_v = 1'b1;
        tick();
        chk("flush_no_pop", 32'(fifo_pop_o), 32'd0);
        tick();
        chk("flush_o_pulse", 32'(fifo_flush_o), 32'd1);
        chk("flush_busy", 32'(busy_o), 32'd1);
        chk("flush_valid", 32'(m_valid_o), 32'd0);
        chk("flush_level", 32'(level_o), 32'd0);
        chk("flush_no_pop2", 32'(fifo_pop_o), 32'd0);
        flush_v = 1'b0;
        tick();
        chk("reflush_o_pulse", 32'(fifo_flush_o), 32'd1);
        chk("reflush_busy", 32'(busy_o), 32'd1);
        tick();
        chk("flush_o_single", 32'(fifo_flush_o), 32'd0);
        k = 0;
        while (busy_o && k < 10) begin
            tick();
            k++;
        end
        chk("flush_exit", 32'(busy_o), 32'd0);
        load(16'h00AA);
        drain(20, "flush_new_data");

        // Asynchronous reset mid-stream, then streaming resumes
        for (int i = 0; i < 8; i++) load(16'h0200 + 16'(i));
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst_v = 1'b1;
        rst_i = 1'b1;
        #1;
        chk_zero_outputs("async_rst");
        fq.delete();
        rq.delete();
        exp_q.delete();
        tick();
        tick();
        rst_v = 1'b0;
        tick();
        run_stream("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
